// File: rtl/stoch_count_decode.sv
// Stochastic-to-binary decoder: counts ones over back-to-back windows of
// 2^WINDOW_BITS qualified samples and delivers each count via valid/ready.
module stoch_count_decode #(
  parameter int unsigned WINDOW_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 a,
  input  logic                 clear,
  output logic [WINDOW_BITS:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 overrun,
  output logic                 window_busy
);

  localparam logic [WINDOW_BITS-1:0] CNT_ONE  = WINDOW_BITS'(1);
  localparam logic [WINDOW_BITS-1:0] CNT_LAST = '1;

  logic [WINDOW_BITS-1:0] cnt_q, cnt_d;
  logic [WINDOW_BITS:0]   acc_q, acc_d;
  logic [WINDOW_BITS:0]   y_q, y_d;
  logic                   y_valid_q, y_valid_d;
  logic                   overrun_q, overrun_d;

  logic [WINDOW_BITS:0]   a_ext;
  logic [WINDOW_BITS:0]   result;
  logic                   final_smp;
  logic                   slot_free;

  assign a_ext     = {{WINDOW_BITS{1'b0}}, a};
  assign result    = acc_q + a_ext;
  // clear wins over a final sample: that window is discarded outright
  assign final_smp = en && !clear && (cnt_q == CNT_LAST);
  assign slot_free = !y_valid_q || y_ready;

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = overrun_q;

    if (clear) begin
      cnt_d     = '0;
      acc_d     = '0;
      overrun_d = 1'b0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_ONE;
      acc_d = final_smp ? '0 : result;
    end

    if (final_smp && slot_free) begin
      y_d       = result;
      y_valid_d = 1'b1;
    end else begin
      if (y_valid_q && y_ready) y_valid_d = 1'b0;
      if (final_smp) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y           = y_q;
  assign y_valid     = y_valid_q;
  assign overrun     = overrun_q;
  assign window_busy = (cnt_q != '0) || (acc_q != '0);

endmodule

// File: tb/tb_stoch_count_decode.sv
// Directed bench for stoch_count_decode with 16-sample windows.
module tb_stoch_count_decode;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b0;
  logic       a = 1'b0;
  logic       clear = 1'b0;
  logic       y_ready = 1'b0;
  logic [4:0] y;
  logic       y_valid;
  logic       overrun;
  logic       window_busy;

  int vectors = 0;
  int miscompares = 0;

  stoch_count_decode #(.WINDOW_BITS(4)) dut (
    .CLK(CLK), .RST(RST), .en(en), .a(a), .clear(clear),
    .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .overrun(overrun), .window_busy(window_busy)
  );

  always #5 CLK = ~CLK;

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_samples(input logic [15:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      en = 1'b1;
      a  = pat[k];
      step();
    end
    en = 1'b0;
    a  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (y !== 5'd0) begin miscompares++; $display("FAIL reset_y: got %0d expected 0", y); end
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", y_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    vectors++; if (window_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", window_busy); end
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_all_ones();
    y_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      en = 1'b1; a = 1'b1;
      step();
      if (k < 15) begin
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL ones_early_valid: sample %0d got %0b expected 0", k, y_valid); end
      end
    end
    vectors++; if (y_valid !== 1'b1) begin miscompares++; $display("FAIL ones_valid: got %0b expected 1", y_valid); end
    vectors++; if (y !== 5'd16) begin miscompares++; $display("FAIL ones_y: got %0d expected 16", y); end
    a = 1'b0;
    step();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL ones_one_cycle: got %0b expected 0", y_valid); end
    run_samples(16'h0000, 15);
    vectors++; if (y !== 5'd0 || y_valid !== 1'b1) begin miscompares++; $display("FAIL zeros_y: got y=%0d v=%0b expected y=0 v=1", y, y_valid); end
    step();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL zeros_accept: got %0b expected 0", y_valid); end
  endtask

  task automatic test_en_toggle();
    y_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      en = (i % 2 == 0);
      a  = ((i % 4) < 2);
      step();
      if (i == 0) begin
        vectors++; if (window_busy !== 1'b1) begin miscompares++; $display("FAIL toggle_busy: got %0b expected 1", window_busy); end
      end
      if (i < 30) begin
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL toggle_early: cycle %0d got %0b expected 0", i, y_valid); end
      end
    end
    en = 1'b0; a = 1'b0;
    vectors++; if (y !== 5'd8 || y_valid !== 1'b1) begin miscompares++; $display("FAIL toggle_y: got y=%0d v=%0b expected y=8 v=1", y, y_valid); end
    y_ready = 1'b1;
    step();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL toggle_accept: got %0b expected 0", y_valid); end
  endtask

  task automatic test_overrun();
    y_ready = 1'b0;
    run_samples(16'h001F, 16);
    vectors++; if (y !== 5'd5 || y_valid !== 1'b1 || overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first: got y=%0d v=%0b o=%0b expected y=5 v=1 o=0", y, y_valid, overrun); end
    run_samples(16'h01FF, 16);
    vectors++; if (y !== 5'd5 || y_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_hold: got y=%0d v=%0b expected y=5 v=1", y, y_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %0b expected 1", overrun); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++; if (overrun !== 1'b0 || y !== 5'd5 || y_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_clear: got o=%0b y=%0d v=%0b expected o=0 y=5 v=1", overrun, y, y_valid); end
    y_ready = 1'b1;
    step();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_accept: got %0b expected 0", y_valid); end
  endtask

  task automatic test_back_to_back();
    y_ready = 1'b0;
    run_samples(16'h0007, 16);
    vectors++; if (y !== 5'd3 || y_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_first: got y=%0d v=%0b expected y=3 v=1", y, y_valid); end
    run_samples(16'h0FFF, 15);
    vectors++; if (y !== 5'd3 || y_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_wait: got y=%0d v=%0b expected y=3 v=1", y, y_valid); end
    en = 1'b1; a = 1'b0; y_ready = 1'b1;
    step();
    en = 1'b0;
    vectors++; if (y !== 5'd12 || y_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_y: got y=%0d v=%0b expected y=12 v=1", y, y_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %0b expected 0", overrun); end
    step();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got %0b expected 0", y_valid); end
  endtask

  task automatic test_clear_final();
    y_ready = 1'b1;
    run_samples(16'hFFFF, 15);
    en = 1'b1; a = 1'b1; clear = 1'b1;
    step();
    en = 1'b0; clear = 1'b0;
    vectors++; if (y_valid !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL clr_noload: got v=%0b o=%0b expected v=0 o=0", y_valid, overrun); end
    vectors++; if (window_busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy: got %0b expected 0", window_busy); end
    y_ready = 1'b0;
    run_samples(16'h007F, 16);
    vectors++; if (y !== 5'd7 || y_valid !== 1'b1) begin miscompares++; $display("FAIL clr_next: got y=%0d v=%0b expected y=7 v=1", y, y_valid); end
    y_ready = 1'b1;
    step();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL clr_accept: got %0b expected 0", y_valid); end
  endtask

  task automatic test_async_reset();
    y_ready = 1'b0;
    run_samples(16'h00FF, 16);
    run_samples(16'h0003, 16);
    vectors++; if (overrun !== 1'b1 || y !== 5'd8) begin miscompares++; $display("FAIL arst_pre: got o=%0b y=%0d expected o=1 y=8", overrun, y); end
    run_samples(16'h03FF, 10);
    #1;
    RST = 1'b1;
    #1;
    vectors++; if (y !== 5'd0) begin miscompares++; $display("FAIL arst_y: got %0d expected 0", y); end
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %0b expected 0", y_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL arst_overrun: got %0b expected 0", overrun); end
    vectors++; if (window_busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %0b expected 0", window_busy); end
    #1;
    RST = 1'b0;
    step();
    run_samples(16'h1F0F, 16);
    vectors++; if (y !== 5'd9 || y_valid !== 1'b1) begin miscompares++; $display("FAIL arst_fresh: got y=%0d v=%0b expected y=9 v=1", y, y_valid); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_en_toggle();
    test_overrun();
    test_back_to_back();
    test_clear_final();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
